// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming encoder: FSM states, codeword bit
// positions and the reference 11->16 encode function. HAMENC_VERIFY_EN adds read-back states.
package hamming_pkg;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAPT,
    WR_LO,
    WR_HI,
`ifdef HAMENC_VERIFY_EN
    RB_LO,
    RB_HI,
    RB_CHK,
`endif
    DONE
  } enc_state_t;

  // Layout {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}; p0 makes the whole word even parity.
  function automatic logic [15:0] hamming_encode(input logic [11:1] d);
    logic [15:0] c;
    c        = '0;
    c[15:9]  = d[11:5];
    c[7:5]   = d[4:2];
    c[3]     = d[1];
    c[P8]    = ^d[11:5];
    c[P4]    = (^d[11:8]) ^ (^d[4:2]);
    c[P2]    = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    c[P1]    = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    c[P0]    = (^d) ^ c[P8] ^ c[P4] ^ c[P2] ^ c[P1];
    return c;
  endfunction

endpackage

// File: rtl/hamming_enc_engine_if.sv
// Memory-port and control bundle of the Hamming encoder engine.
// master = engine side, slave = memory/controller side.
interface hamming_enc_engine_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;
  logic              verify_err;

  modport master (
    input  start, mem_rd_data,
    output done, mem_addr, mem_wr_en, mem_wr_data, verify_err
  );

  modport slave (
    output start, mem_rd_data,
    input  done, mem_addr, mem_wr_en, mem_wr_data, verify_err
  );
endinterface

// File: rtl/hamming_enc_engine_parity_gen.sv
// Combinational 11-bit message to 16-bit SECDED codeword encoder.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [10:0] d_i,
  output logic [15:0] cw_o
);
  assign cw_o = hamming_encode(d_i);
endmodule

// File: rtl/hamming_enc_engine.sv
// Hamming encoder engine: reads NUM_MSG messages from byte memory, writes codewords back.
// HAMENC_VERIFY_EN adds a read-back check of each codeword with a sticky verify_err.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  hamming_enc_engine_if.master bus
);
  localparam int                IDX_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [ADDR_W-1:0] SRC      = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST      = ADDR_W'(DST_BASE);

  enc_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q;
  logic [15:0]       cw_q, cw_w;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              verr_q, verr_d;

  // {idx,hi} is 2*idx+hi; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic hi);
    return base + ADDR_W'({idx, hi});
  endfunction

  hamming_parity_gen u_pgen (
    .d_i  ({bus.mem_rd_data[2:0], lo_q}),
    .cw_o (cw_w)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    verr_d  = verr_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RD_LO;
          idx_d   = '0;
          done_d  = 1'b0;
          verr_d  = 1'b0;
        end
      end
      RD_LO: state_d = RD_HI;
      RD_HI: state_d = CAPT;
      CAPT:  state_d = WR_LO;
      WR_LO: state_d = WR_HI;
`ifdef HAMENC_VERIFY_EN
      WR_HI: state_d = RB_LO;
      RB_LO: state_d = RB_HI;
      RB_HI: begin
        if (bus.mem_rd_data != cw_q[7:0]) verr_d = 1'b1;
        state_d = RB_CHK;
      end
      RB_CHK: begin
        if (bus.mem_rd_data != cw_q[15:8]) verr_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD_LO;
        end
      end
`else
      WR_HI: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD_LO;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state, so they line up with the state cycle.
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    case (state_d)
      RD_LO: addr_d = byte_addr(SRC, idx_d, 1'b0);
      RD_HI: addr_d = byte_addr(SRC, idx_d, 1'b1);
      WR_LO: begin
        wr_en_d   = 1'b1;
        addr_d    = byte_addr(DST, idx_d, 1'b0);
        wr_data_d = cw_w[7:0];
      end
      WR_HI: begin
        wr_en_d   = 1'b1;
        addr_d    = byte_addr(DST, idx_d, 1'b1);
        wr_data_d = cw_q[15:8];
      end
`ifdef HAMENC_VERIFY_EN
      RB_LO: addr_d = byte_addr(DST, idx_d, 1'b0);
      RB_HI: addr_d = byte_addr(DST, idx_d, 1'b1);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lo_q      <= '0;
      cw_q      <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      verr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      verr_q    <= verr_d;
      if (state_q == RD_HI) lo_q <= bus.mem_rd_data;
      if (state_q == CAPT)  cw_q <= cw_w;
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.done        = done_q;
`ifdef HAMENC_VERIFY_EN
  assign bus.verify_err  = verr_q;
`else
  assign bus.verify_err  = 1'b0;
  logic unused_verr;
  assign unused_verr = verr_q ^ verr_d;
`endif

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine: a 15-message instance checked through a write
// scoreboard and a 1-message instance checked against fixed codewords.
module tb_hamming_enc_engine;
`ifdef HAMENC_VERIFY_EN
  localparam int CPM = 8;
`else
  localparam int CPM = 5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hamming_enc_engine_if #(.ADDR_W(8)) bus0 ();
  hamming_enc_engine_if #(.ADDR_W(8)) bus1 ();

  hamming_enc_engine #(.NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) dut (
    .clk (clk), .reset (reset), .bus (bus0.master));
  hamming_enc_engine #(.NUM_MSG(1), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) dut1 (
    .clk (clk), .reset (reset), .bus (bus1.master));

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  bit          corrupt = 1'b0;
  int          passed = 0;
  int          total = 0;
  logic [15:0] sbq [$];
  logic [15:0] expcw [15];

  // Registered-read byte memories; read returns the pre-write contents.
  always @(posedge clk) begin
    bus0.mem_rd_data <= mem0[bus0.mem_addr];
    bus1.mem_rd_data <= mem1[bus1.mem_addr];
    if (bus0.mem_wr_en)
      mem0[bus0.mem_addr] = (corrupt && bus0.mem_addr == 8'd32) ?
                            (bus0.mem_wr_data ^ 8'h01) : bus0.mem_wr_data;
    if (bus1.mem_wr_en) mem1[bus1.mem_addr] = bus1.mem_wr_data;
  end

  function automatic logic [15:0] model(input logic [10:0] m);
    logic d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11;
    logic p1, p2, p4, p8;
    logic [15:0] c;
    {d11, d10, d9, d8, d7, d6, d5, d4, d3, d2, d1} = m;
    p8 = d11 ^ d10 ^ d9 ^ d8 ^ d7 ^ d6 ^ d5;
    p4 = d11 ^ d10 ^ d9 ^ d8 ^ d4 ^ d3 ^ d2;
    p2 = d11 ^ d10 ^ d7 ^ d6 ^ d4 ^ d3 ^ d1;
    p1 = d11 ^ d9 ^ d7 ^ d5 ^ d4 ^ d2 ^ d1;
    c = {d11, d10, d9, d8, d7, d6, d5, p8, d4, d3, d2, p4, d1, p2, p1, 1'b0};
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Every write of the 15-message engine must be the next expected (addr,data) pair.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset && bus0.mem_wr_en) begin
      chk("wr_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("wr_addr_data", {16'h0, bus0.mem_addr, bus0.mem_wr_data}, {16'h0, e});
      end
    end
  end

  task automatic load_msgs();
    logic [7:0] lo, hi;
    sbq.delete();
    for (int i = 0; i < 15; i++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      mem0[2*i]   = lo;
      mem0[2*i+1] = hi;
      expcw[i]    = model({hi[2:0], lo});
      sbq.push_back({8'(30 + 2*i), expcw[i][7:0]});
      sbq.push_back({8'(31 + 2*i), expcw[i][15:8]});
    end
  endtask

  task automatic start_and_wait(input string tag, input bit mid_pulse, input bit check_mem);
    int n;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    chk({tag, "_done_clr"}, 32'(bus0.done), 32'd0);
    chk({tag, "_verr_clr"}, 32'(bus0.verify_err), 32'd0);
    n = 0;
    while (!bus0.done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      bus0.start = (mid_pulse && n == 20);
    end
    bus0.start = 1'b0;
    chk({tag, "_done_cyc"}, 32'(n), 32'(15 * CPM));
    chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    if (check_mem)
      for (int i = 0; i < 15; i++)
        chk({tag, "_cw"}, {16'h0, mem0[31+2*i], mem0[30+2*i]}, {16'h0, expcw[i]});
  endtask

  task automatic run1(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [15:0] exp);
    int n;
    mem1[0] = lo;
    mem1[1] = hi;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    n = 0;
    while (!bus1.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_cyc"}, 32'(n), 32'(CPM));
    chk({tag, "_cw"}, {16'h0, mem1[31], mem1[30]}, {16'h0, exp});
  endtask

  initial begin
    int  n;
    bit  found;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end

    #2;
    chk("rst_done",    32'(bus0.done),        32'd0);
    chk("rst_wr_en",   32'(bus0.mem_wr_en),   32'd0);
    chk("rst_addr",    32'(bus0.mem_addr),    32'd0);
    chk("rst_wr_data", 32'(bus0.mem_wr_data), 32'd0);
    chk("rst_verr",    32'(bus0.verify_err),  32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run1("t1_d001", 8'h01, 8'h00, 16'h000F);
    run1("t2_d400", 8'h00, 8'h04, 16'h8117);
    run1("t2_d7ff", 8'hFF, 8'h07, 16'hFFFF);
    run1("t2_d000", 8'h00, 8'h00, 16'h0000);
    run1("t3_hiFC", 8'hFF, 8'hFC, model(11'h4FF));
    run1("t3_hi04", 8'hFF, 8'h04, model(11'h4FF));

    load_msgs();
    start_and_wait("t4_rand", 1'b0, 1'b1);
    chk("t4_verr", 32'(bus0.verify_err), 32'd0);

    // Abort during message 7's low-byte write, then rerun from scratch.
    load_msgs();
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(posedge clk); #1;
      n++;
      found = bus0.mem_wr_en && bus0.mem_addr == 8'd44;
    end
    chk("t5_reach_msg7", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_done",  32'(bus0.done),      32'd0);
    chk("t5_rst_wr_en", 32'(bus0.mem_wr_en), 32'd0);
    chk("t5_rst_addr",  32'(bus0.mem_addr),  32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    load_msgs();
    start_and_wait("t5_rerun", 1'b0, 1'b1);

    load_msgs();
    start_and_wait("t6_midstart", 1'b1, 1'b1);

`ifdef HAMENC_VERIFY_EN
    corrupt = 1'b1;
    load_msgs();
    start_and_wait("t6_corrupt", 1'b0, 1'b0);
    chk("t6_verr_set", 32'(bus0.verify_err), 32'd1);
    corrupt = 1'b0;
    load_msgs();
    start_and_wait("t6_clean", 1'b0, 1'b1);
    chk("t6_verr_clean", 32'(bus0.verify_err), 32'd0);
`else
    chk("t6_verr_tied", 32'(bus0.verify_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
